// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encodings and debug command bytes
package uart_pkg;

  // Ticks per bit; the receiver samples data and stop bits on the last tick of each bit
  localparam int OVERSAMPLE = 16;

  // Receiver FSM encodings, also exported on o_rx_state for debug
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Debug command bytes understood by the debug unit
  localparam logic [7:0] CMD_CONT = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_LOAD = 8'h64;  // 'd'
  localparam logic [7:0] CMD_NEXT = 8'h6E;  // 'n'

  // Instruction word that marks the end of a program load
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversample tick generator shared by RX and TX
module baud_tick_gen #(
  parameter int BAUD_DIVISOR = 326
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIVISOR - 1);

  logic [CW-1:0] r_count;

  // Tick is a decode of the terminal count so it lasts exactly one clock
  assign o_tick = (r_count == LAST);

  // Count 0..BAUD_DIVISOR-1 and wrap; never resynchronized to the RX line
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled 8N1 receiver with sticky done/error flags
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SIZE_TRAMA   = 8,
  parameter int BAUD_DIVISOR = 326,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  input  logic                  i_rx_reset,
  output logic [SIZE_TRAMA-1:0] o_rx_data,
  output logic                  o_rx_done,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic [1:0]            o_rx_state
);

  // Start bit is confirmed half a bit in; data and stop bits are sampled a full bit later
  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] N_LAST = 3'(SIZE_TRAMA - 1);

  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic                  w_tick;
  logic                  w_done_held;
  rx_state_t             r_state;
  logic [3:0]            r_s_cnt;
  logic [2:0]            r_n_cnt;
  logic [SIZE_TRAMA-1:0] r_shreg;
  logic [SIZE_TRAMA-1:0] r_rx_data;
  logic                  r_rx_done;
  logic                  r_frame_err;
  logic                  r_overrun;

  baud_tick_gen #(
    .BAUD_DIVISOR(BAUD_DIVISOR)
  ) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );

  // A byte still waiting counts as unread only if the consumer is not clearing it this cycle
  assign w_done_held = r_rx_done & ~i_rx_reset;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame FSM with registered byte and sticky flags; a completion overrides a same-cycle clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_s_cnt     <= '0;
      r_n_cnt     <= '0;
      r_shreg     <= '0;
      r_rx_data   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_rx_reset) begin
        r_rx_done   <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_s_cnt <= '0;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (r_s_cnt == S_MID) begin
              if (!r_rx_s) begin
                r_state <= ST_DATA;
                r_s_cnt <= '0;
                r_n_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_s_cnt == S_LAST) begin
              r_shreg <= {r_rx_s, r_shreg[SIZE_TRAMA-1:1]};
              r_s_cnt <= '0;
              if (r_n_cnt == N_LAST) begin
                r_state <= ST_STOP;
              end else begin
                r_n_cnt <= r_n_cnt + 1'b1;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_s_cnt == S_LAST) begin
              r_state <= ST_IDLE;
              if (r_rx_s) begin
                if (!w_done_held) begin
                  r_rx_data <= r_shreg;
                  r_rx_done <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_done   = r_rx_done;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_rx_state  = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int DIV = 4;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;
  logic [1:0] rx_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_receiver #(
    .SIZE_TRAMA  (8),
    .BAUD_DIVISOR(DIV),
    .OVERSAMPLE  (16)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx       (rx),
    .i_rx_reset (rx_reset),
    .o_rx_data  (rx_data),
    .o_rx_done  (rx_done),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .o_rx_state (rx_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is held low only 40 clocks so the line is high again before a false start is confirmed
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT);
    end
    if (stop_ok) begin
      rx = 1'b1;
      idle(BIT);
    end else begin
      rx = 1'b0;
      idle(40);
      rx = 1'b1;
      idle(BIT - 40);
    end
    rx = 1'b1;
  endtask

  task automatic pulse_clear();
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;

    rst      = 1'b1;
    rx       = 1'b1;
    rx_reset = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_data",  rx_data,   32'h0);
    check("reset_done",  rx_done,   32'h0);
    check("reset_ferr",  frame_err, 32'h0);
    check("reset_ovr",   overrun,   32'h0);
    check("reset_state", rx_state,  32'h0);

    // 0x64 with latency measured from the start edge
    lat = 0;
    fork
      send_frame(8'h64, 1'b1);
      begin
        while (!rx_done && lat < 800) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("d_latency_in_window", (lat >= 600 && lat <= 620), 32'h1);
    check("d_data", rx_data, 32'h64);
    check("d_done", rx_done, 32'h1);
    idle(50);
    check("d_done_sticky", rx_done, 32'h1);
    pulse_clear();
    check("d_done_cleared", rx_done, 32'h0);

    // short low glitch is rejected
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(100);
    check("glitch_state", rx_state,  32'h0);
    check("glitch_done",  rx_done,   32'h0);
    check("glitch_ferr",  frame_err, 32'h0);

    // framing error on 0x73
    send_frame(8'h73, 1'b0);
    idle(40);
    check("ferr_set",   frame_err, 32'h1);
    check("ferr_done",  rx_done,   32'h0);
    check("ferr_data",  rx_data,   32'h64);
    check("ferr_state", rx_state,  32'h0);
    pulse_clear();
    check("ferr_cleared", frame_err, 32'h0);

    // overrun: 0x63 then 0x6E without clearing
    send_frame(8'h63, 1'b1);
    idle(10);
    check("c_done", rx_done, 32'h1);
    check("c_data", rx_data, 32'h63);
    send_frame(8'h6E, 1'b1);
    idle(10);
    check("ovr_set",  overrun, 32'h1);
    check("ovr_data", rx_data, 32'h63);
    check("ovr_done", rx_done, 32'h1);

    // clear coincides with completion: STOP lasts exactly 16 ticks = 64 clocks from entry
    fork
      send_frame(8'h6E, 1'b1);
      begin
        n = 0;
        while (rx_state != 2'd3 && n < 700) begin
          @(negedge clk);
          n++;
        end
        check("n_stop_reached", (n < 700), 32'h1);
        idle(63);
        rx_reset = 1'b1;
        @(negedge clk);
        rx_reset = 1'b0;
        check("n_done_wins", rx_done, 32'h1);
        check("n_data",      rx_data, 32'h6E);
        check("n_ovr_clear", overrun, 32'h0);
      end
    join

    // reset during bit 4 of 0xFF, then 0x55
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(BIT * 5 + 32);
        rst = 1'b1;
        idle(2);
        check("rst_state", rx_state, 32'h0);
        check("rst_done",  rx_done,  32'h0);
        check("rst_data",  rx_data,  32'h0);
        rst = 1'b0;
      end
    join
    idle(20);
    check("post_rst_idle_done", rx_done, 32'h0);
    send_frame(8'h55, 1'b1);
    idle(10);
    check("u_data", rx_data,   32'h55);
    check("u_done", rx_done,   32'h1);
    check("u_ferr", frame_err, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
